// File: rtl/binary_erode.sv
// binary_erode: thresholds a 12-bit pixel onto the half-resolution binary grid,
// keeps three binary lines and outputs the 3x3 AND (erosion) of the window
// two clocks after the hcount/vcount sample.
// Build option: BINARY_ERODE_PAD_ONE_EN makes out-of-image taps read as 1, so a
// solid image stays solid up to its borders. When it is not defined, those taps
// read as 0 and the output always has a one-pixel border of zeros.
module binary_erode #(
    parameter int H_ADDR_TIME = 800,
    parameter int V_ADDR_TIME = 600,
    parameter int WIDTH       = H_ADDR_TIME >> 1,
    parameter int HEIGHT      = V_ADDR_TIME >> 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic [11:0] pixel_in,
    input  logic [11:0] threshold,
    output logic        erode_value,
    output logic        erode_valid
);

`ifdef BINARY_ERODE_PAD_ONE_EN
    localparam logic PAD = 1'b1;
`else
    localparam logic PAD = 1'b0;
`endif

    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] line_buf_0;
    logic [WIDTH-1:0] line_buf_1;
    logic [WIDTH-1:0] line_buf_2;

    logic [10:0] x;
    logic [10:0] y;
    logic        b;
    logic        wr_en;
    logic        shift_en;

    logic        a0_d, a1_d, a2_d, cv_d;
    logic        a0_q, a1_q, a2_q, cv_q;

    assign x = {1'b0, hcount[10:1]};
    assign y = {1'b0, vcount[10:1]};
    assign b = (pixel_in >= threshold);

    // Writes happen on the even scan pixel of each even scan line inside the image;
    // the shift happens at the start of each even line.
    assign wr_en    = rst && !vcount[0] && !hcount[0] && (x < 11'(WIDTH))
                      && (vcount < 11'(V_ADDR_TIME));
    assign shift_en = rst && !vcount[0] && (hcount == 11'd0);

    // Reads one tap of a row. A column index that underflowed wraps to a large
    // value, so the single range compare also covers x<2 without touching memory.
    function automatic logic tap(input logic [WIDTH-1:0] row, input logic row_ok,
                                 input logic [10:0] col);
        logic [AW-1:0] idx;
        idx = col[AW-1:0];
        if (row_ok && (col < 11'(WIDTH)))
            return row[idx];
        else
            return PAD;
    endfunction

    // Line buffers: shift whole lines in one clock, write the new binary pixel.
    // On a coinciding shift and write, the shift copies the old line_buf_2.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            line_buf_0 <= line_buf_1;
            line_buf_1 <= line_buf_2;
        end
        if (wr_en)
            line_buf_2[x[AW-1:0]] <= b;
    end

    // Row ANDs over columns x-2..x, with row validity derived from y-2..y.
    always_comb begin
        logic r0_ok, r1_ok, r2_ok;
        r0_ok = ((y - 11'd2) < 11'(HEIGHT));
        r1_ok = ((y - 11'd1) < 11'(HEIGHT));
        r2_ok = (y < 11'(HEIGHT));
        a0_d  = tap(line_buf_0, r0_ok, x - 11'd2) & tap(line_buf_0, r0_ok, x - 11'd1)
                & tap(line_buf_0, r0_ok, x);
        a1_d  = tap(line_buf_1, r1_ok, x - 11'd2) & tap(line_buf_1, r1_ok, x - 11'd1)
                & tap(line_buf_1, r1_ok, x);
        a2_d  = tap(line_buf_2, r2_ok, x - 11'd2) & tap(line_buf_2, r2_ok, x - 11'd1)
                & tap(line_buf_2, r2_ok, x);
        cv_d  = (x >= 11'd1) && (x <= 11'(WIDTH)) && (y >= 11'd1) && (y <= 11'(HEIGHT));
    end

    // Stage 1: register the three row ANDs and the window-centre validity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a0_q <= 1'b0;
            a1_q <= 1'b0;
            a2_q <= 1'b0;
            cv_q <= 1'b0;
        end else begin
            a0_q <= a0_d;
            a1_q <= a1_d;
            a2_q <= a2_d;
            cv_q <= cv_d;
        end
    end

    // Stage 2: combine rows; an invalid centre always yields 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            erode_value <= 1'b0;
            erode_valid <= 1'b0;
        end else begin
            erode_value <= cv_q & a0_q & a1_q & a2_q;
            erode_valid <= cv_q;
        end
    end

endmodule

// File: tb/tb_binary_erode.sv
// Testbench for binary_erode on a reduced 40x24 scan (20x12 binary image).
module tb_binary_erode;
    localparam int H_ADDR = 40;
    localparam int V_ADDR = 24;
    localparam int W      = H_ADDR >> 1;
    localparam int HT     = V_ADDR >> 1;
    localparam int H_TOT  = 46;
    localparam int V_TOT  = 28;
    localparam int YR     = 6;

`ifdef BINARY_ERODE_PAD_ONE_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount = '0;
    logic [10:0] vcount = '0;
    logic [11:0] pixel_in = '0;
    logic [11:0] threshold = '0;
    logic        erode_value;
    logic        erode_valid;

    binary_erode #(.H_ADDR_TIME(H_ADDR), .V_ADDR_TIME(V_ADDR)) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .pixel_in(pixel_in), .threshold(threshold),
        .erode_value(erode_value), .erode_valid(erode_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit val;
        bit dc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_cnt = 0;
    bit   rst_q = 1'b0;
    bit   img[HT][W];

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rst_q    <= rst;
    end

    // Erosion of the binary image around centre (x-1,y-1) using rows y-2..y and
    // columns x-2..x. On an even scan line at an even scan pixel, column x of row y
    // is being written by this very sample, so the window still sees row y-1 there.
    function automatic bit model(input int x, input int y, input int hc, input int vc);
        bit v;
        bit t;
        int r;
        int c;
        v = 1'b1;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dcol = 0; dcol < 3; dcol++) begin
                r = y - 2 + dr;
                c = x - 2 + dcol;
                if (r < 0 || r >= HT || c < 0 || c >= W)
                    t = PAD;
                else if (dr == 2 && dcol == 2 && (vc % 2) == 0 && (hc % 2) == 0)
                    t = img[y-1][x];
                else
                    t = img[r][c];
                v = v & t;
            end
        end
        return v;
    endfunction

    // Monitor: every output cycle is compared against the scoreboard head.
    always @(negedge clk) begin
        bit   exp_now;
        exp_t e;
        exp_now = (q.size() > 0) && (q[0].cyc == edge_cnt);
        if (!rst_q) begin
            checks++;
            if (erode_valid !== 1'b0 || erode_value !== 1'b0) begin
                errors++;
                $display("FAIL reset_out cyc=%0d got valid=%b value=%b want 0/0",
                         edge_cnt, erode_valid, erode_value);
            end
        end
        if (exp_now) begin
            e = q.pop_front();
            checks++;
            if (erode_valid !== 1'b1) begin
                errors++;
                $display("FAIL missing_valid cyc=%0d got valid=%b want 1", edge_cnt, erode_valid);
            end else if (!e.dc && erode_value !== e.val) begin
                errors++;
                $display("FAIL erode_value cyc=%0d got %b want %b", edge_cnt, erode_value, e.val);
            end
        end else begin
            checks++;
            if (erode_valid !== 1'b0) begin
                errors++;
                $display("FAIL spurious_valid cyc=%0d got valid=%b want 0", edge_cnt, erode_valid);
            end else if (erode_value !== 1'b0) begin
                errors++;
                $display("FAIL value_when_invalid cyc=%0d got %b want 0", edge_cnt, erode_value);
            end
        end
    end

    task automatic drive(input int hc, input int vc, input int pix, input int thr,
                         input bit rv, input bit rn, input bit dcv);
        int x;
        int y;
        bit cv;
        @(posedge clk);
        #1;
        rst       = rv;
        hcount    = 11'(hc);
        vcount    = 11'(vc);
        pixel_in  = 12'(pix);
        threshold = 12'(thr);
        x  = hc >> 1;
        y  = vc >> 1;
        cv = (x >= 1) && (x <= W) && (y >= 1) && (y <= HT);
        if (rv && rn && cv)
            q.push_back('{cyc: edge_cnt + 2, val: model(x, y, hc, vc), dc: dcv});
        if (rv && (vc % 2) == 0 && (hc % 2) == 0 && x < W && vc < V_ADDR)
            img[y][x] = (pix >= thr);
    endtask

    // mode: 0 ones, 1 single pixel, 2 5x5 block, 3 thr==pix, 4 thr==pix+1, 5 random
    task automatic run_frame(input int mode, input bit with_reset);
        int rs;
        int idx;
        int pix;
        int thr;
        int x;
        int y;
        bit rv;
        bit rn;
        bit dcv;
        rs = (2 * YR - 1) * H_TOT + H_TOT - 1;
        for (int vc = 0; vc < V_TOT; vc++) begin
            for (int hc = 0; hc < H_TOT; hc++) begin
                idx = vc * H_TOT + hc;
                x   = hc >> 1;
                y   = vc >> 1;
                rv  = !(with_reset && idx >= rs && idx < rs + 3);
                rn  = !(with_reset && idx + 1 >= rs && idx + 1 < rs + 3);
                dcv = with_reset && y >= YR && y < YR + 3;
                case (mode)
                    0: begin pix = 4095; thr = 2048; end
                    1: begin pix = (x == 10 && y == 5) ? 4095 : 0; thr = 2048; end
                    2: begin
                        pix = (x >= 10 && x <= 14 && y >= 5 && y <= 9) ? 4095 : 0;
                        thr = 2048;
                    end
                    3: begin pix = 1000; thr = 1000; end
                    4: begin pix = 1000; thr = 1001; end
                    default: begin
                        pix = int'($urandom_range(0, 4095));
                        thr = int'($urandom_range(0, 700));
                    end
                endcase
                drive(hc, vc, pix, thr, rv, rn, dcv);
            end
        end
    endtask

    initial begin
        int budget;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        run_frame(2, 1'b0);
        run_frame(3, 1'b0);
        run_frame(4, 1'b0);
        run_frame(5, 1'b0);
        run_frame(5, 1'b1);
        run_frame(0, 1'b0);
        run_frame(5, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(2047, 2047, 0, 0, 1'b1, 1'b1, 1'b0);
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
